vga_sync_monitor: RTL and testbench

// Receive side of the VGA timing path: samples an incoming active-low hsync/vsync pair,

---
 rtl/vga_sync_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_monitor
// Brief   : Receive-side VGA sync monitor. Measures line/frame geometry and
//           sync pulse widths, regenerates h/v counters and flags lock.
//           Define VGA_MON_POL_DETECT_EN for automatic sync polarity detection
//           (adds hs_pol/vs_pol outputs).
// Revision: 1.0 - initial release
// ============================================================================
module vga_sync_monitor #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 2,
    parameter int H_TOL       = 1
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             px_ce,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] hs_width,
    output logic [CNT_W-1:0] vs_width,
    output logic             line_start,
    output logic             frame_start,
`ifdef VGA_MON_POL_DETECT_EN
    output logic             hs_pol,
    output logic             vs_pol,
`endif
    output logic             locked
);

    localparam logic [1:0]       c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0]       c_ST_ARMED    = 2'd1;
    localparam logic [1:0]       c_ST_CHECK    = 2'd2;
    localparam logic [1:0]       c_ST_LOCKED   = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_H_TOL       = CNT_W'(H_TOL);
    localparam logic [CNT_W-1:0] c_LOCK        = CNT_W'(LOCK_FRAMES);

    logic [1:0]       r_hs_sync, r_vs_sync;
    logic [1:0]       w_raw, r_raw_prev, w_pol, w_act, w_act_prev, w_lead, w_trail;
    logic             w_pol_chg;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hs_wcnt, r_vs_wcnt, r_h_ref, r_v_ref, r_match;
    logic [CNT_W-1:0] w_h_meas, w_v_meas, w_h_dev, w_h_ref_new;
    logic             r_frame_bad, w_frame_bad, w_line_bad, w_v_ok, w_sat;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_sync <= 2'b11;
            r_vs_sync <= 2'b11;
        end else begin
            r_hs_sync <= {r_hs_sync[0], hs_in};
            r_vs_sync <= {r_vs_sync[0], vs_in};
        end
    end

    assign w_raw = {r_vs_sync[1], r_hs_sync[1]};

`ifdef VGA_MON_POL_DETECT_EN
    localparam int c_PW = 2 * CNT_W;
    logic [1:0][c_PW-1:0] r_hi_cnt, r_lo_cnt;
    logic [1:0]           r_pol, r_seen, w_pol_new, w_pol_upd;

    assign w_pol_new = {r_hi_cnt[1] < r_lo_cnt[1], r_hi_cnt[0] < r_lo_cnt[0]};
    assign w_pol_upd = {2{px_ce}} & w_raw & ~r_raw_prev & r_seen;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
            r_pol    <= '0;
            r_seen   <= '0;
        end else if (px_ce) begin
            for (int a = 0; a < 2; a++) begin
                // each raw rising edge closes one full period; the shorter level is the pulse
                if (w_raw[a] && !r_raw_prev[a]) begin
                    if (r_seen[a]) r_pol[a] <= w_pol_new[a];
                    r_seen[a]   <= 1'b1;
                    r_hi_cnt[a] <= c_PW'(1);
                    r_lo_cnt[a] <= '0;
                end else if (w_raw[a]) begin
                    if (r_hi_cnt[a] != {c_PW{1'b1}}) r_hi_cnt[a] <= r_hi_cnt[a] + 1'b1;
                end else if (r_lo_cnt[a] != {c_PW{1'b1}}) begin
                    r_lo_cnt[a] <= r_lo_cnt[a] + 1'b1;
                end
            end
        end
    end

    assign w_pol     = r_pol;
    assign w_pol_chg = |(w_pol_upd & (w_pol_new ^ r_pol));
    assign hs_pol    = r_pol[0];
    assign vs_pol    = r_pol[1];
`else
    assign w_pol     = 2'b00;
    assign w_pol_chg = 1'b0;
`endif

    // bit 0 = horizontal axis, bit 1 = vertical axis; act=1 means pulse active
    assign w_act       = w_raw ^ ~w_pol;
    assign w_act_prev  = r_raw_prev ^ ~w_pol;
    assign w_lead      = {2{px_ce}} & w_act & ~w_act_prev;
    assign w_trail     = {2{px_ce}} & ~w_act & w_act_prev;

    assign w_h_meas    = (h_cnt == c_CNT_MAX) ? c_CNT_MAX : h_cnt + 1'b1;
    assign w_v_meas    = (v_cnt == c_CNT_MAX) ? c_CNT_MAX : v_cnt + 1'b1;
    assign w_h_dev     = (w_h_meas >= r_h_ref) ? (w_h_meas - r_h_ref) : (r_h_ref - w_h_meas);
    assign w_line_bad  = w_h_dev > c_H_TOL;
    assign w_frame_bad = r_frame_bad | (w_lead[0] & w_line_bad);
    assign w_v_ok      = (w_v_meas == r_v_ref);
    assign w_h_ref_new = w_lead[0] ? w_h_meas : h_total;
    assign w_sat       = (h_cnt == c_CNT_MAX) | (v_cnt == c_CNT_MAX);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_prev  <= 2'b11;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_total     <= '0;
            v_total     <= '0;
            hs_width    <= '0;
            vs_width    <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            r_state     <= c_ST_UNLOCKED;
            r_hs_wcnt   <= '0;
            r_vs_wcnt   <= '0;
            r_h_ref     <= '0;
            r_v_ref     <= '0;
            r_match     <= '0;
            r_frame_bad <= 1'b0;
        end else begin
            line_start  <= w_lead[0];
            frame_start <= w_lead[1];
            if (px_ce) begin
                r_raw_prev <= w_raw;

                if (w_lead[0]) begin
                    h_total <= w_h_meas;
                    h_cnt   <= '0;
                end else if (h_cnt != c_CNT_MAX) begin
                    h_cnt <= h_cnt + 1'b1;
                end
                if (w_lead[0])                               r_hs_wcnt <= CNT_W'(1);
                else if (w_act[0] && r_hs_wcnt != c_CNT_MAX) r_hs_wcnt <= r_hs_wcnt + 1'b1;
                if (w_trail[0]) hs_width <= r_hs_wcnt;

                // v_total takes the pre-increment line count, so a coincident hs edge is not double counted
                if (w_lead[1]) begin
                    v_total <= w_v_meas;
                    v_cnt   <= '0;
                end else if (w_lead[0] && v_cnt != c_CNT_MAX) begin
                    v_cnt <= v_cnt + 1'b1;
                end
                if (w_lead[1])                                            r_vs_wcnt <= CNT_W'(1);
                else if (w_lead[0] && w_act[1] && r_vs_wcnt != c_CNT_MAX) r_vs_wcnt <= r_vs_wcnt + 1'b1;
                if (w_trail[1]) vs_width <= r_vs_wcnt;

                if (w_lead[1])                    r_frame_bad <= 1'b0;
                else if (w_lead[0] && w_line_bad) r_frame_bad <= 1'b1;

                if (w_sat || w_pol_chg) begin
                    r_state <= c_ST_UNLOCKED;
                    locked  <= 1'b0;
                end else begin
                    case (r_state)
                        c_ST_UNLOCKED: if (w_lead[1]) r_state <= c_ST_ARMED;
                        c_ST_ARMED: if (w_lead[1]) begin
                            r_state <= c_ST_CHECK;
                            r_h_ref <= w_h_ref_new;
                            r_v_ref <= w_v_meas;
                            r_match <= '0;
                        end
                        c_ST_CHECK: if (w_lead[1]) begin
                            if (!w_frame_bad && w_v_ok) begin
                                if (r_match + 1'b1 == c_LOCK) begin
                                    r_state <= c_ST_LOCKED;
                                    locked  <= 1'b1;
                                end
                                r_match <= r_match + 1'b1;
                            end else begin
                                r_h_ref <= w_h_ref_new;
                                r_v_ref <= w_v_meas;
                                r_match <= '0;
                            end
                        end
                        default: if ((w_lead[0] && w_line_bad) || (w_lead[1] && !w_v_ok)) begin
                            r_state <= c_ST_UNLOCKED;
                            locked  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_sync_monitor
// Brief   : Self-checking bench for vga_sync_monitor using randomised small
//           video geometries and a frame-level expectation model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_sync_monitor;

    localparam int CNT_W = 12;

    logic             clk_50 = 1'b0;
    logic             rst_n  = 1'b0;
    logic             px_ce  = 1'b0;
    logic             hs_in  = 1'b1;
    logic             vs_in  = 1'b1;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_total, v_total, hs_width, vs_width;
    logic             line_start, frame_start, locked;
`ifdef VGA_MON_POL_DETECT_EN
    logic             hs_pol, vs_pol;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // geometry of the generated stream: total pixels/lines and pulse widths
    int H, HW, V, VW;

    // snapshot taken at every observed frame_start pulse
    int               fs_cnt = 0;
    logic             fs_locked, fs_line;
    logic [CNT_W-1:0] fs_h, fs_v;

    vga_sync_monitor #(.CNT_W(CNT_W), .LOCK_FRAMES(2), .H_TOL(1)) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .px_ce       (px_ce),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_total     (h_total),
        .v_total     (v_total),
        .hs_width    (hs_width),
        .vs_width    (vs_width),
        .line_start  (line_start),
        .frame_start (frame_start),
`ifdef VGA_MON_POL_DETECT_EN
        .hs_pol      (hs_pol),
        .vs_pol      (vs_pol),
`endif
        .locked      (locked)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    task automatic new_geometry();
        H  = $urandom_range(20, 32);
        HW = $urandom_range(2, 6);
        V  = $urandom_range(6, 10);
        VW = $urandom_range(1, 3);
    endtask

    task automatic step(input logic ce, input logic hs, input logic vs);
        @(negedge clk_50);
        px_ce = ce;
        hs_in = hs;
        vs_in = vs;
        @(posedge clk_50);
        #1;
        if (frame_start === 1'b1) begin
            fs_cnt++;
            fs_locked = locked;
            fs_line   = line_start;
            fs_h      = h_cnt;
            fs_v      = v_cnt;
        end
    endtask

    // one pixel = two clocks, px_ce on the second; sync inputs are active-low
    task automatic pixel(input logic hs_act, input logic vs_act);
        step(1'b0, !hs_act, !vs_act);
        step(1'b1, !hs_act, !vs_act);
    endtask

    task automatic line(input int len, input logic vs_act);
        for (int x = 0; x < len; x++) pixel(x < HW, vs_act);
    endtask

    task automatic frame();
        for (int y = 0; y < V; y++) line(H, y < VW);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
        n_total++;
        if ({h_cnt, v_cnt} !== '0) $display("FAIL reset_counters: got %h want 0", {h_cnt, v_cnt});
        else n_pass++;
        n_total++;
        if ({h_total, v_total, hs_width, vs_width} !== '0)
            $display("FAIL reset_measure: got %h want 0", {h_total, v_total, hs_width, vs_width});
        else n_pass++;
        n_total++;
        if ({line_start, frame_start, locked} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {line_start, frame_start, locked});
        else n_pass++;
        @(negedge clk_50);
        rst_n = 1'b1;
    endtask

    // after reset, lock appears at the 4th vsync edge and then holds
    task automatic test_lock_sequence();
        int base;
        new_geometry();
        base = fs_cnt;
        for (int f = 1; f <= 12; f++) begin
            frame();
            n_total++;
            if (fs_cnt !== base + f) $display("FAIL lock_edge_seen: got %0d edges want %0d", fs_cnt - base, f);
            else n_pass++;
            n_total++;
            if (fs_locked !== (f >= 4)) $display("FAIL lock_at_edge%0d: got %b want %b", f, fs_locked, f >= 4);
            else n_pass++;
            if (f == 3) begin
                n_total++;
                if (h_total !== CNT_W'(H)) $display("FAIL h_total: got %0d want %0d", h_total, H);
                else n_pass++;
                n_total++;
                if (v_total !== CNT_W'(V)) $display("FAIL v_total: got %0d want %0d", v_total, V);
                else n_pass++;
                n_total++;
                if (hs_width !== CNT_W'(HW)) $display("FAIL hs_width: got %0d want %0d", hs_width, HW);
                else n_pass++;
                n_total++;
                if (vs_width !== CNT_W'(VW)) $display("FAIL vs_width: got %0d want %0d", vs_width, VW);
                else n_pass++;
            end
            if (f == 5) begin
                n_total++;
                if (fs_line !== 1'b1) $display("FAIL same_sample_line_start: got %b want 1", fs_line);
                else n_pass++;
                n_total++;
                if (fs_h !== '0) $display("FAIL same_sample_h_cnt: got %0d want 0", fs_h);
                else n_pass++;
                n_total++;
                if (fs_v !== '0) $display("FAIL same_sample_v_cnt: got %0d want 0", fs_v);
                else n_pass++;
            end
        end
    endtask

    // deviation of delta pixels on one line: |delta|>1 drops lock, |delta|<=1 keeps it
    task automatic test_line_deviation(input int mag);
        int j, d, base;
        logic exp_lock;
        j = $urandom_range(1, V - 2);
        d = ($urandom_range(0, 1) == 1) ? mag : -mag;
        exp_lock = (mag <= 1);
        for (int y = 0; y < V; y++) begin
            line((y == j) ? H + d : H, y < VW);
            if (y == j) begin
                n_total++;
                if (locked !== 1'b1) $display("FAIL dev%0d_before_edge: got %b want 1", mag, locked);
                else n_pass++;
            end
            if (y == j + 1) begin
                n_total++;
                if (locked !== exp_lock) $display("FAIL dev%0d_at_edge: got %b want %b", mag, locked, exp_lock);
                else n_pass++;
                n_total++;
                if (h_total !== CNT_W'(H + d)) $display("FAIL dev%0d_h_total: got %0d want %0d", mag, h_total, H + d);
                else n_pass++;
            end
        end
        base = fs_cnt;
        for (int f = 1; f <= 4; f++) begin
            frame();
            n_total++;
            if (fs_cnt !== base + f) $display("FAIL dev%0d_edge_seen: got %0d want %0d", mag, fs_cnt - base, f);
            else n_pass++;
            n_total++;
            if (fs_locked !== (exp_lock || f >= 4))
                $display("FAIL dev%0d_relock_edge%0d: got %b want %b", mag, f, fs_locked, exp_lock || f >= 4);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        for (int y = 0; y < 3; y++) line(H, y < VW);
        n_total++;
        if (locked !== 1'b1) $display("FAIL sat_pre_locked: got %b want 1", locked);
        else n_pass++;
        for (int i = 0; i < 4200; i++) pixel(1'b0, 1'b0);
        n_total++;
        if (h_cnt !== 12'd4095) $display("FAIL sat_h_cnt: got %0d want 4095", h_cnt);
        else n_pass++;
        n_total++;
        if (v_cnt !== 12'd2) $display("FAIL sat_v_cnt: got %0d want 2", v_cnt);
        else n_pass++;
        n_total++;
        if (h_total !== CNT_W'(H)) $display("FAIL sat_h_total: got %0d want %0d", h_total, H);
        else n_pass++;
        n_total++;
        if (locked !== 1'b0) $display("FAIL sat_locked: got %b want 0", locked);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        int base;
        for (int f = 0; f < 7; f++) frame();
        n_total++;
        if (locked !== 1'b1) $display("FAIL rst_pre_locked: got %b want 1", locked);
        else n_pass++;
        line(H, 1'b0);
        line(H, 1'b0);
        line(H / 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({h_cnt, v_cnt, h_total, v_total, hs_width, vs_width} !== '0)
            $display("FAIL rst_async_values: got %h want 0", {h_cnt, v_cnt, h_total, v_total, hs_width, vs_width});
        else n_pass++;
        n_total++;
        if ({line_start, frame_start, locked} !== 3'b000)
            $display("FAIL rst_async_flags: got %b want 000", {line_start, frame_start, locked});
        else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        @(negedge clk_50);
        rst_n = 1'b1;
        new_geometry();
        base = fs_cnt;
        for (int f = 1; f <= 5; f++) begin
            frame();
            n_total++;
            if (fs_cnt !== base + f) $display("FAIL rst_edge_seen: got %0d want %0d", fs_cnt - base, f);
            else n_pass++;
            n_total++;
            if (fs_locked !== (f >= 4)) $display("FAIL rst_relock_edge%0d: got %b want %b", f, fs_locked, f >= 4);
            else n_pass++;
        end
        n_total++;
        if (v_total !== CNT_W'(V)) $display("FAIL rst_v_total: got %0d want %0d", v_total, V);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_line_deviation($urandom_range(2, 3));
        test_line_deviation(1);
        test_saturation();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
